// File: rtl/blink_pkg.sv
// blink_pkg: mode encoding and default counter width shared by the LED blink generator
package blink_pkg;
   typedef enum logic [1:0] {
      MODE_OFF     = 2'd0,
      MODE_ON      = 2'd1,
      MODE_BLINK   = 2'd2,
      MODE_ONESHOT = 2'd3
   } mode_t;
   localparam int CNT_W_DEF = 24;
endpackage

// File: rtl/blink_channel.sv
// blink_channel: one LED channel with mode register, half-period counter, LED flop and tick
module blink_channel
   import blink_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             wr,
   input  logic [1:0]       mode,
   input  logic [CNT_W-1:0] half,
   output logic             led,
   output logic             tick
);
   mode_t            mode_q, mode_d;
   logic [CNT_W-1:0] half_q, half_d, cnt_q, cnt_d;
   logic             led_d, timed;
   assign timed = mode_q == MODE_BLINK || mode_q == MODE_ONESHOT;
   // a write on the terminal cycle suppresses the toggle and its tick
   assign tick = en && timed && cnt_q == half_q - 1'b1 && !wr;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode_q <= MODE_OFF;
         half_q <= CNT_W'(1);
         cnt_q  <= '0;
         led    <= 1'b0;
      end else begin
         mode_q <= mode_d;
         half_q <= half_d;
         cnt_q  <= cnt_d;
         led    <= led_d;
      end
   end
   always_comb begin
      mode_d = mode_q;
      half_d = half_q;
      cnt_d  = cnt_q;
      led_d  = led;
      if (wr) begin
         mode_d = mode_t'(mode);
         half_d = half == '0 ? CNT_W'(1) : half;
         cnt_d  = '0;
         led_d  = mode_t'(mode) != MODE_OFF;
      end else if (tick) begin
         mode_d = mode_q == MODE_ONESHOT ? MODE_OFF : mode_q;
         cnt_d  = '0;
         led_d  = mode_q == MODE_BLINK && !led;
      end else if (en && timed) begin
         cnt_d = cnt_q + 1'b1;
      end
   end
endmodule

// File: rtl/param_blink_gen.sv
// param_blink_gen: N_CH independent LED blinkers behind a one-write-per-two-cycles config port
module param_blink_gen
   import blink_pkg::*;
#(
   parameter int N_CH  = 4,
   parameter int CNT_W = CNT_W_DEF,
   parameter int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             en_i,
   input  logic             cfg_valid_i,
   output logic             cfg_ready_o,
   input  logic [CH_W-1:0]  cfg_ch_i,
   input  logic [1:0]       cfg_mode_i,
   input  logic [CNT_W-1:0] cfg_half_i,
   output logic             cfg_err_o,
   output logic [N_CH-1:0]  LED_po,
   output logic [N_CH-1:0]  tick_o
);
   localparam logic [CH_W:0] N_CH_LIM = (CH_W + 1)'(N_CH);
   logic            accept;
   logic [CH_W:0]   ch_ext;
   logic [N_CH-1:0] wr;
   assign accept = cfg_valid_i && cfg_ready_o;
   assign ch_ext = {1'b0, cfg_ch_i};
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         cfg_ready_o <= 1'b0;
         cfg_err_o   <= 1'b0;
      end else begin
         cfg_ready_o <= !accept;
         cfg_err_o   <= accept && ch_ext >= N_CH_LIM;
      end
   end
   genvar i;
   generate
      for (i = 0; i < N_CH; i++) begin : g_ch
         assign wr[i] = accept && ch_ext == (CH_W + 1)'(i);
         blink_channel #(.CNT_W(CNT_W)) u_ch (
            .clk   (clk_i),
            .rst_n (rst_n_i),
            .en    (en_i),
            .wr    (wr[i]),
            .mode  (cfg_mode_i),
            .half  (cfg_half_i),
            .led   (LED_po[i]),
            .tick  (tick_o[i])
         );
      end
   endgenerate
endmodule

// File: tb/tb_param_blink_gen.sv
// tb_param_blink_gen: directed checks of reset, blink, oneshot, handshake, error and freeze behaviour
module tb_param_blink_gen;
   logic        clk_i = 1'b0;
   logic        rst_n_i = 1'b0;
   logic        en_i = 1'b0;
   logic        cfg_valid_i = 1'b0;
   logic        cfg_ready_o;
   logic [2:0]  cfg_ch_i = '0;
   logic [1:0]  cfg_mode_i = '0;
   logic [23:0] cfg_half_i = '0;
   logic        cfg_err_o;
   logic [3:0]  LED_po, tick_o;
   int          n_cmp = 0;
   int          n_bad = 0;
   int          n_tick;
   param_blink_gen #(.N_CH(4), .CNT_W(24), .CH_W(3)) dut (
      .clk_i       (clk_i),
      .rst_n_i     (rst_n_i),
      .en_i        (en_i),
      .cfg_valid_i (cfg_valid_i),
      .cfg_ready_o (cfg_ready_o),
      .cfg_ch_i    (cfg_ch_i),
      .cfg_mode_i  (cfg_mode_i),
      .cfg_half_i  (cfg_half_i),
      .cfg_err_o   (cfg_err_o),
      .LED_po      (LED_po),
      .tick_o      (tick_o)
   );
   always #5 clk_i = ~clk_i;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic stp();
      @(posedge clk_i);
      #1;
   endtask
   task automatic wr(input int ch, input int mode, input int half);
      if (!cfg_ready_o) stp();
      cfg_valid_i = 1'b1;
      cfg_ch_i    = ch[2:0];
      cfg_mode_i  = mode[1:0];
      cfg_half_i  = half[23:0];
      stp();
      cfg_valid_i = 1'b0;
      #1;
   endtask
   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end
   initial begin
      repeat (3) stp();
      chk("rst_led", LED_po, 0);
      chk("rst_tick", tick_o, 0);
      chk("rst_err", cfg_err_o, 0);
      chk("rst_ready", cfg_ready_o, 0);
      rst_n_i = 1'b1;
      #1;
      chk("ready_before_edge", cfg_ready_o, 0);
      stp();
      chk("ready_after_edge", cfg_ready_o, 1);
      en_i = 1'b1;
      wr(0, 2, 5);
      for (int k = 0; k < 20; k++) begin
         chk($sformatf("blink0_led_%0d", k), LED_po, ((k / 5) % 2 == 0) ? 4'b0001 : 4'b0000);
         chk($sformatf("blink0_tick_%0d", k), tick_o, (k % 5 == 4) ? 4'b0001 : 4'b0000);
         chk($sformatf("blink0_ready_%0d", k), cfg_ready_o, (k == 0) ? 0 : 1);
         chk($sformatf("blink0_err_%0d", k), cfg_err_o, 0);
         stp();
      end
      wr(0, 0, 1);
      chk("ch0_off", LED_po, 0);
      wr(2, 3, 3);
      n_tick = 0;
      for (int k = 0; k < 6; k++) begin
         chk($sformatf("oneshot2_led_%0d", k), LED_po, (k < 3) ? 4'b0100 : 4'b0000);
         chk($sformatf("oneshot2_tick_%0d", k), tick_o, (k == 2) ? 4'b0100 : 4'b0000);
         n_tick += int'(tick_o[2]);
         stp();
      end
      chk("oneshot2_tick_count", n_tick, 1);
      for (int k = 0; k < 4; k++) begin
         cfg_valid_i = 1'b1;
         cfg_ch_i    = 3'(k);
         cfg_mode_i  = 2'd1;
         cfg_half_i  = 24'd1;
         #1;
         chk($sformatf("b2b_ready_%0d", k), cfg_ready_o, (k % 2 == 0) ? 1 : 0);
         stp();
      end
      cfg_valid_i = 1'b0;
      #1;
      chk("b2b_accepted", LED_po, 4'b0101);
      wr(0, 0, 1);
      wr(2, 0, 1);
      chk("b2b_cleared", LED_po, 0);
      wr(1, 2, 4);
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("blink1_led_%0d", k), LED_po, 4'b0010);
         chk($sformatf("blink1_tick_%0d", k), tick_o, 0);
         stp();
      end
      cfg_valid_i = 1'b1;
      cfg_ch_i    = 3'd1;
      cfg_mode_i  = 2'd1;
      cfg_half_i  = 24'd4;
      #1;
      chk("term_write_ready", cfg_ready_o, 1);
      chk("term_write_no_tick", tick_o, 0);
      stp();
      cfg_valid_i = 1'b0;
      #1;
      for (int k = 0; k < 6; k++) begin
         chk($sformatf("on1_led_%0d", k), LED_po, 4'b0010);
         chk($sformatf("on1_tick_%0d", k), tick_o, 0);
         stp();
      end
      wr(1, 0, 1);
      chk("ch1_off", LED_po, 0);
      stp();
      chk("err_idle", cfg_err_o, 0);
      wr(5, 1, 1);
      chk("err_pulse", cfg_err_o, 1);
      chk("err_led", LED_po, 0);
      chk("err_ready", cfg_ready_o, 0);
      stp();
      chk("err_clear", cfg_err_o, 0);
      chk("err_led_after", LED_po, 0);
      wr(3, 2, 0);
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("fast3_led_%0d", k), LED_po, (k % 2 == 0) ? 4'b1000 : 4'b0000);
         chk($sformatf("fast3_tick_%0d", k), tick_o, 4'b1000);
         stp();
      end
      chk("fast3_led_4", LED_po, 4'b1000);
      en_i = 1'b0;
      #1;
      chk("freeze_tick", tick_o, 0);
      for (int k = 0; k < 3; k++) begin
         stp();
         chk($sformatf("freeze_led_%0d", k), LED_po, 4'b1000);
         chk($sformatf("freeze_tick_%0d", k), tick_o, 0);
      end
      wr(0, 1, 1);
      chk("frozen_write", LED_po, 4'b1001);
      #2;
      rst_n_i = 1'b0;
      #1;
      chk("async_rst_led", LED_po, 0);
      chk("async_rst_tick", tick_o, 0);
      chk("async_rst_ready", cfg_ready_o, 0);
      chk("async_rst_err", cfg_err_o, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
